// File: rtl/sample_mux_pkg.sv
// Shared mode encodings, scan FSM state type and a clog2 helper for sample_mux.
package sample_mux_pkg;

  localparam logic [1:0] MODE_MANUAL = 2'b00;
  localparam logic [1:0] MODE_SCAN   = 2'b01;
  localparam logic [1:0] MODE_XOR    = 2'b10;
  localparam logic [1:0] MODE_HOLD   = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DWELL = 2'd1,
    ST_STEP  = 2'd2
  } scan_state_e;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < n) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/sample_mux_scan_ctrl.sv
// Scan sequencer: walks channels 0..NCH-1, dwell+1 samples each, with one idle STEP cycle between channels.
module scan_ctrl
  import sample_mux_pkg::*;
#(
  parameter int NCH     = 4,
  parameter int SEL_W   = 2,
  parameter int DWELL_W = 8
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [1:0]         mode_i,
  input  logic               en_i,
  input  logic [DWELL_W-1:0] dwell_i,
  output logic [SEL_W-1:0]   ch_o,
  output logic               sample_o,
  output logic               step_o
);

  scan_state_e        state_q, state_d;
  logic [SEL_W-1:0]   ptr_q, ptr_d;
  logic [DWELL_W-1:0] cnt_q, cnt_d;
  logic [SEL_W-1:0]   ptr_eff;
  logic [DWELL_W-1:0] cnt_eff;

  // IDLE behaves as a fresh DWELL at channel 0 so the first SCAN edge already samples.
  assign ptr_eff = (state_q == ST_IDLE) ? '0 : ptr_q;
  assign cnt_eff = (state_q == ST_IDLE) ? '0 : cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      ptr_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    cnt_d   = cnt_q;
    if (mode_i != MODE_SCAN) begin
      state_d = ST_IDLE;
    end else if (en_i) begin
      case (state_q)
        ST_STEP: begin
          ptr_d   = (32'(ptr_q) == NCH - 1) ? '0 : ptr_q + 1'b1;
          cnt_d   = '0;
          state_d = ST_DWELL;
        end
        default: begin
          ptr_d = ptr_eff;
          if (cnt_eff == dwell_i) begin
            cnt_d   = cnt_eff;
            state_d = ST_STEP;
          end else begin
            cnt_d   = cnt_eff + 1'b1;
            state_d = ST_DWELL;
          end
        end
      endcase
    end
  end

  always_comb begin
    ch_o     = ptr_eff;
    sample_o = (mode_i == MODE_SCAN) && en_i && (state_q != ST_STEP);
    step_o   = (state_q == ST_STEP);
  end

endmodule

// File: rtl/sample_mux.sv
// Registered channel multiplexer with manual, scan, XOR-reduce and hold modes.
// Define SAMPLE_MUX_XOR_EN to build the XOR reduction; otherwise mode 10 acts as MANUAL.
module sample_mux
  import sample_mux_pkg::*;
#(
  parameter int WIDTH   = 4,
  parameter int NCH     = 4,
  parameter int DWELL_W = 8,
  localparam int SEL_W  = (clog2(NCH) > 1) ? clog2(NCH) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NCH*WIDTH-1:0] in_bus,
  input  logic [SEL_W-1:0]     sel,
  input  logic [1:0]           mode,
  input  logic [DWELL_W-1:0]   dwell,
  input  logic                 en,
  output logic [WIDTH-1:0]     out_mux,
  output logic                 out_valid,
  output logic [SEL_W-1:0]     out_ch
);

  logic [WIDTH-1:0] ch_w [NCH];
  logic [WIDTH-1:0] out_mux_q, out_mux_d;
  logic [SEL_W-1:0] out_ch_q, out_ch_d;
  logic             out_valid_q, out_valid_d;
  logic             arm_q;
  logic             en_eff;
  logic [SEL_W-1:0] man_ch;
  logic [SEL_W-1:0] scan_ch;
  logic             scan_sample, scan_step;

  genvar gi;
  generate
    for (gi = 0; gi < NCH; gi++) begin : g_ch
      assign ch_w[gi] = in_bus[gi*WIDTH +: WIDTH];
    end
  endgenerate

  // The first edge after reset release only arms the block, so no sample is emitted on it.
  assign en_eff = en & arm_q;
  assign man_ch = (32'(sel) < NCH) ? sel : '0;

  scan_ctrl #(
    .NCH     (NCH),
    .SEL_W   (SEL_W),
    .DWELL_W (DWELL_W)
  ) u_scan_ctrl (
    .clk      (clk),
    .rst_n    (rst_n),
    .mode_i   (mode),
    .en_i     (en_eff),
    .dwell_i  (dwell),
    .ch_o     (scan_ch),
    .sample_o (scan_sample),
    .step_o   (scan_step)
  );

`ifdef SAMPLE_MUX_XOR_EN
  logic [WIDTH-1:0] xor_all;
  always_comb begin
    xor_all = '0;
    for (int k = 0; k < NCH; k++) xor_all = xor_all ^ ch_w[k];
  end
`endif

  always_comb begin
    out_mux_d   = out_mux_q;
    out_ch_d    = out_ch_q;
    out_valid_d = 1'b0;
    if (en_eff) begin
      case (mode)
        MODE_SCAN: begin
          if (scan_sample && !scan_step) begin
            out_mux_d   = ch_w[scan_ch];
            out_ch_d    = scan_ch;
            out_valid_d = 1'b1;
          end
        end
        MODE_HOLD: begin
          out_valid_d = 1'b0;
        end
`ifdef SAMPLE_MUX_XOR_EN
        MODE_XOR: begin
          out_mux_d   = xor_all;
          out_ch_d    = '0;
          out_valid_d = 1'b1;
        end
`endif
        default: begin
          out_mux_d   = ch_w[man_ch];
          out_ch_d    = man_ch;
          out_valid_d = 1'b1;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_mux_q   <= '0;
      out_ch_q    <= '0;
      out_valid_q <= 1'b0;
      arm_q       <= 1'b0;
    end else begin
      out_mux_q   <= out_mux_d;
      out_ch_q    <= out_ch_d;
      out_valid_q <= out_valid_d;
      arm_q       <= 1'b1;
    end
  end

  assign out_mux   = out_mux_q;
  assign out_ch    = out_ch_q;
  assign out_valid = out_valid_q;

endmodule
